// File: rtl/datapath_rr_scheduler.sv
// Round-robin front end for one shared multicycle combinational datapath.
// One operand is in flight at a time. Each result returns on a valid/ready port tagged with the requester index.
module datapath_rr_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int IN_W     = 4,
    parameter int OUT_W    = 23,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 16,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int LAT_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         dp_input_data,
    input  logic [OUT_W-1:0]        dp_output_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUT_W-1:0]        rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        txn_count,
    output logic [1:0]              dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requests may change or drop until they are accepted. Responses stay fixed while rsp_valid is high without rsp_ready.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [LAT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [IN_W-1:0]    operand_q, operand_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]   txn_count_q, txn_count_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand_idx;
    int                 cand;

    // The scan starts at rr_ptr, so the requester just served gets the lowest priority next.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand_idx = ID_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        operand_d   = operand_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        txn_count_d = txn_count_q;
        req_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    operand_d  = req_data[grant_idx*IN_W +: IN_W];
                    rsp_id_d   = grant_idx;
                    rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                    wait_cnt_d = LAT_W'(PIPE_LAT-1);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_data_d  = dp_output_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            operand_q   <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            operand_q   <= operand_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign dp_input_data = operand_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_id        = rsp_id_q;
    assign txn_count     = txn_count_q;
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

endmodule
